// File: rtl/attack_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : attack_sequencer_if
// Description : Bundles the frame/button/game-state inputs and the attack
//               outputs of one attack_sequencer instance.
//               master : the driver of buttons, frame tick and game state
//               slave  : the attack_sequencer itself
// Signals     : frame_tick   one-clk pulse per animation frame
//               btn_light    light button level (synchronized)
//               btn_medium   medium button level (synchronized)
//               btn_heavy    heavy button level (synchronized)
//               game_state   00 fight, 01 P1 wins, 10 P2 wins
//               attack_state strike pulse: 00 none, 01/10/11 light/med/heavy
//               attack_type  attack in progress (00 when idle)
//               phase        00 IDLE, 01 STARTUP, 10 ACTIVE, 11 RECOVERY
//               busy         high whenever phase != IDLE
// Revision    : 1.0 - initial release
// ============================================================================
interface attack_sequencer_if;
  logic       frame_tick;
  logic       btn_light;
  logic       btn_medium;
  logic       btn_heavy;
  logic [1:0] game_state;
  logic [1:0] attack_state;
  logic [1:0] attack_type;
  logic [1:0] phase;
  logic       busy;

  modport master (
    output frame_tick, btn_light, btn_medium, btn_heavy, game_state,
    input  attack_state, attack_type, phase, busy
  );

  modport slave (
    input  frame_tick, btn_light, btn_medium, btn_heavy, game_state,
    output attack_state, attack_type, phase, busy
  );
endinterface
`default_nettype wire

// File: rtl/attack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : attack_sequencer
// Description : Per-player attack generator. A button press starts a timed
//               STARTUP -> ACTIVE -> RECOVERY sequence paced by frame_tick.
//               A one-clk strike pulse (attack_state) is emitted on the first
//               clk of ACTIVE so each attack deals damage exactly once.
// Ports       : clk    system clock
//               reset  synchronous active-high reset
//               bus    attack_sequencer_if.slave (buttons, frame tick,
//                      game state in; strike, type, phase, busy out)
// Options     : ATTACK_BUFFER_EN - when defined, the highest-priority press
//               seen during RECOVERY is buffered and launched directly on
//               RECOVERY exit. When undefined, presses while busy are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module attack_sequencer #(
  parameter int CNT_W      = 5,
  parameter int L_STARTUP  = 2,
  parameter int L_ACTIVE   = 2,
  parameter int L_RECOVERY = 4,
  parameter int M_STARTUP  = 4,
  parameter int M_ACTIVE   = 3,
  parameter int M_RECOVERY = 8,
  parameter int H_STARTUP  = 8,
  parameter int H_ACTIVE   = 4,
  parameter int H_RECOVERY = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  attack_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    PH_IDLE     = 2'b00,
    PH_STARTUP  = 2'b01,
    PH_ACTIVE   = 2'b10,
    PH_RECOVERY = 2'b11
  } phase_t;

  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_l_stu = CNT_W'(L_STARTUP);
  localparam logic [CNT_W-1:0] c_l_act = CNT_W'(L_ACTIVE);
  localparam logic [CNT_W-1:0] c_l_rec = CNT_W'(L_RECOVERY);
  localparam logic [CNT_W-1:0] c_m_stu = CNT_W'(M_STARTUP);
  localparam logic [CNT_W-1:0] c_m_act = CNT_W'(M_ACTIVE);
  localparam logic [CNT_W-1:0] c_m_rec = CNT_W'(M_RECOVERY);
  localparam logic [CNT_W-1:0] c_h_stu = CNT_W'(H_STARTUP);
  localparam logic [CNT_W-1:0] c_h_act = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_h_rec = CNT_W'(H_RECOVERY);

  // Per-type frame counts; type 00 never gets loaded, so it shares heavy.
  function automatic logic [CNT_W-1:0] f_startup(input logic [1:0] t);
    case (t)
      2'b01:   return c_l_stu;
      2'b10:   return c_m_stu;
      default: return c_h_stu;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] f_active(input logic [1:0] t);
    case (t)
      2'b01:   return c_l_act;
      2'b10:   return c_m_act;
      default: return c_h_act;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] f_recovery(input logic [1:0] t);
    case (t)
      2'b01:   return c_l_rec;
      2'b10:   return c_m_rec;
      default: return c_h_rec;
    endcase
  endfunction

  phase_t           r_phase, w_phase_nxt;
  logic [1:0]       r_type, w_type_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_strike, w_strike_nxt;
  logic             r_light_q, r_medium_q, r_heavy_q;
  logic [1:0]       w_press;
`ifdef ATTACK_BUFFER_EN
  logic [1:0]       r_buf, w_buf_nxt;
`endif

  // Rising-edge press, encoded so that a larger code is a higher priority.
  always_comb begin
    w_press = 2'b00;
    if (bus.btn_heavy & ~r_heavy_q)        w_press = 2'b11;
    else if (bus.btn_medium & ~r_medium_q) w_press = 2'b10;
    else if (bus.btn_light & ~r_light_q)   w_press = 2'b01;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase    <= PH_IDLE;
      r_type     <= 2'b00;
      r_cnt      <= '0;
      r_strike   <= 2'b00;
      r_light_q  <= 1'b0;
      r_medium_q <= 1'b0;
      r_heavy_q  <= 1'b0;
`ifdef ATTACK_BUFFER_EN
      r_buf      <= 2'b00;
`endif
    end else begin
      r_phase    <= w_phase_nxt;
      r_type     <= w_type_nxt;
      r_cnt      <= w_cnt_nxt;
      r_strike   <= w_strike_nxt;
      r_light_q  <= bus.btn_light;
      r_medium_q <= bus.btn_medium;
      r_heavy_q  <= bus.btn_heavy;
`ifdef ATTACK_BUFFER_EN
      r_buf      <= w_buf_nxt;
`endif
    end
  end

  always_comb begin
    w_phase_nxt  = r_phase;
    w_type_nxt   = r_type;
    w_cnt_nxt    = r_cnt;
    // Strike is only raised on the STARTUP->ACTIVE edge, so it self-clears.
    w_strike_nxt = 2'b00;
`ifdef ATTACK_BUFFER_EN
    w_buf_nxt    = r_buf;
`endif
    if (bus.game_state != 2'b00) begin
      w_phase_nxt = PH_IDLE;
      w_type_nxt  = 2'b00;
      w_cnt_nxt   = '0;
`ifdef ATTACK_BUFFER_EN
      w_buf_nxt   = 2'b00;
`endif
    end else begin
      case (r_phase)
        PH_IDLE: begin
          if (w_press != 2'b00) begin
            w_phase_nxt = PH_STARTUP;
            w_type_nxt  = w_press;
            w_cnt_nxt   = f_startup(w_press);
          end
        end
        PH_STARTUP: begin
`ifdef ATTACK_BUFFER_EN
          if (w_press != 2'b00) w_buf_nxt = 2'b00;
`endif
          if (bus.frame_tick) begin
            if (r_cnt == c_one) begin
              w_phase_nxt  = PH_ACTIVE;
              w_cnt_nxt    = f_active(r_type);
              w_strike_nxt = r_type;
            end else begin
              w_cnt_nxt = r_cnt - c_one;
            end
          end
        end
        PH_ACTIVE: begin
`ifdef ATTACK_BUFFER_EN
          if (w_press != 2'b00) w_buf_nxt = 2'b00;
`endif
          if (bus.frame_tick) begin
            if (r_cnt == c_one) begin
              w_phase_nxt = PH_RECOVERY;
              w_cnt_nxt   = f_recovery(r_type);
            end else begin
              w_cnt_nxt = r_cnt - c_one;
            end
          end
        end
        PH_RECOVERY: begin
`ifdef ATTACK_BUFFER_EN
          if (w_press > r_buf) w_buf_nxt = w_press;
`endif
          if (bus.frame_tick) begin
            if (r_cnt == c_one) begin
`ifdef ATTACK_BUFFER_EN
              // Chain straight into the buffered attack, skipping IDLE.
              if (w_buf_nxt != 2'b00) begin
                w_phase_nxt = PH_STARTUP;
                w_type_nxt  = w_buf_nxt;
                w_cnt_nxt   = f_startup(w_buf_nxt);
                w_buf_nxt   = 2'b00;
              end else begin
                w_phase_nxt = PH_IDLE;
                w_type_nxt  = 2'b00;
                w_cnt_nxt   = '0;
              end
`else
              w_phase_nxt = PH_IDLE;
              w_type_nxt  = 2'b00;
              w_cnt_nxt   = '0;
`endif
            end else begin
              w_cnt_nxt = r_cnt - c_one;
            end
          end
        end
        default: w_phase_nxt = PH_IDLE;
      endcase
    end
  end

  assign bus.attack_state = r_strike;
  assign bus.attack_type  = r_type;
  assign bus.phase        = r_phase;
  assign bus.busy         = (r_phase != PH_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_attack_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_attack_sequencer
// Description : Self-checking bench for attack_sequencer with default
//               parameters. Frame tick every 4 clks. Expected strike pulses
//               (type and frame-tick count at which they appear) are queued
//               when presses are driven and compared when pulses appear.
//               Honours ATTACK_BUFFER_EN for the buffered-press scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_attack_sequencer;

  logic clk;
  logic reset;

  attack_sequencer_if bus ();

  attack_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] typ;
    int         tick;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   tick_cnt = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clk; inputs for the new cycle are applied 1 time unit after
  // the edge. Frame tick falls on every cycle where cyc % 4 == 0.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    bus.frame_tick = (cyc % 4 == 0);
    if (bus.frame_tick) tick_cnt++;
  endtask

  // Land on a cycle without a frame tick so a press does not share a tick.
  task automatic align();
    step();
    while (cyc % 4 != 1) step();
  endtask

  task automatic wait_phase(input logic [1:0] ph, input string tag);
    int n;
    n = 0;
    while (bus.phase != ph && n < 500) begin
      step();
      n++;
    end
    check(tag, int'(bus.phase), int'(ph));
  endtask

  task automatic push(input logic [1:0] typ, input int tick);
    exp_t e;
    e.typ  = typ;
    e.tick = tick;
    sb_q.push_back(e);
  endtask

  // Pulse monitor: every non-zero strike must match the next queued entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      check("busy", int'(bus.busy), int'(bus.phase != 2'b00));
      if (bus.attack_state != 2'b00) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", int'(bus.attack_state), 0);
        end else begin
          e = sb_q.pop_front();
          check("pulse_type", int'(bus.attack_state), int'(e.typ));
          check("pulse_tick", tick_cnt, e.tick);
        end
      end
    end
  end

  initial begin : stim
    int t0;
    int n;
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.btn_light  = 1'b0;
    bus.btn_medium = 1'b0;
    bus.btn_heavy  = 1'b0;
    bus.game_state = 2'b00;
    repeat (3) step();
    check("rst_phase", int'(bus.phase), 0);
    check("rst_type", int'(bus.attack_type), 0);
    check("rst_strike", int'(bus.attack_state), 0);
    check("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;

    // Light attack: 2 / 2 / 4 ticks.
    align();
    t0 = tick_cnt;
    bus.btn_light = 1'b1;
    push(2'b01, t0 + 2);
    step();
    bus.btn_light = 1'b0;
    check("light_phase_startup", int'(bus.phase), 1);
    check("light_type", int'(bus.attack_type), 1);
    wait_phase(2'b10, "light_wait_active");
    check("light_active_at", tick_cnt - t0, 2);
    wait_phase(2'b11, "light_wait_recovery");
    check("light_recovery_at", tick_cnt - t0, 4);
    wait_phase(2'b00, "light_wait_idle");
    check("light_busy_ticks", tick_cnt - t0, 8);
    check("light_type_idle", int'(bus.attack_type), 0);

    // Heavy and light together: heavy wins.
    align();
    t0 = tick_cnt;
    bus.btn_heavy = 1'b1;
    bus.btn_light = 1'b1;
    push(2'b11, t0 + 8);
    step();
    bus.btn_heavy = 1'b0;
    bus.btn_light = 1'b0;
    check("prio_type", int'(bus.attack_type), 3);
    wait_phase(2'b00, "prio_wait_idle");
    check("heavy_busy_ticks", tick_cnt - t0, 28);

    // Medium held for 100 ticks: one attack only.
    align();
    t0 = tick_cnt;
    bus.btn_medium = 1'b1;
    push(2'b10, t0 + 4);
    repeat (400) step();
    check("hold_phase_idle", int'(bus.phase), 0);
    bus.btn_medium = 1'b0;
    step();

    // Game over during STARTUP aborts and blocks new presses.
    align();
    bus.btn_light = 1'b1;
    step();
    bus.btn_light = 1'b0;
    check("go_startup", int'(bus.phase), 1);
    bus.game_state = 2'b01;
    step();
    check("go_phase", int'(bus.phase), 0);
    check("go_type", int'(bus.attack_type), 0);
    bus.btn_heavy = 1'b1;
    repeat (20) step();
    check("go_press_ignored", int'(bus.phase), 0);
    bus.game_state = 2'b00;
    repeat (20) step();
    check("go_held_no_retrigger", int'(bus.phase), 0);
    bus.btn_heavy = 1'b0;
    step();

    // Reset on the heavy STARTUP->ACTIVE tick: no pulse.
    align();
    t0 = tick_cnt;
    bus.btn_heavy = 1'b1;
    step();
    bus.btn_heavy = 1'b0;
    n = 0;
    while (tick_cnt < t0 + 8 && n < 200) begin
      step();
      n++;
    end
    check("rst_mid_reached", int'(bus.phase), 1);
    reset = 1'b1;
    step();
    check("rst_mid_phase", int'(bus.phase), 0);
    check("rst_mid_type", int'(bus.attack_type), 0);
    check("rst_mid_strike", int'(bus.attack_state), 0);
    check("rst_mid_busy", int'(bus.busy), 0);
    reset = 1'b0;
    repeat (8) step();

    // Light pressed during medium RECOVERY.
    align();
    t0 = tick_cnt;
    bus.btn_medium = 1'b1;
    push(2'b10, t0 + 4);
    step();
    bus.btn_medium = 1'b0;
    wait_phase(2'b11, "buf_wait_recovery");
    bus.btn_light = 1'b1;
    step();
    bus.btn_light = 1'b0;
`ifdef ATTACK_BUFFER_EN
    push(2'b01, t0 + 17);
    wait_phase(2'b00, "buf_wait_idle");
    check("buf_busy_ticks", tick_cnt - t0, 23);
`else
    wait_phase(2'b00, "buf_wait_idle");
    check("buf_busy_ticks", tick_cnt - t0, 15);
    repeat (40) step();
    check("buf_stays_idle", int'(bus.phase), 0);
`endif

    repeat (4) step();
    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/attack_sequencer.md
Name: attack_sequencer

Overview:
- Per-player attack generator. Turns debounced, synchronized punch/kick buttons into timed attack sequences: startup, active, then recovery.
- Emits the 2-bit attack code consumed by the health manager. The code is a single-clock strike pulse, so each attack deals damage exactly once.
- Also drives the sprite/animation phase. One instance per player, clocked by the system clock and paced by the shared frame tick.

Parameters:
- CNT_W, 5, width of the frame countdown register
- L_STARTUP, 2, light attack startup frames
- L_ACTIVE, 2, light attack active frames
- L_RECOVERY, 4, light attack recovery frames
- M_STARTUP, 4, medium attack startup frames
- M_ACTIVE, 3, medium attack active frames
- M_RECOVERY, 8, medium attack recovery frames
- H_STARTUP, 8, heavy attack startup frames
- H_ACTIVE, 4, heavy attack active frames
- H_RECOVERY, 16, heavy attack recovery frames
- Legal range: all durations must be in 1..2^CNT_W-1.

Ports:
- clk, input, 1, system clock
- reset, input, 1, synchronous active-high reset
- frame_tick, input, 1, one-clk pulse per animation frame
- btn_light, input, 1, light attack button level (already synchronized)
- btn_medium, input, 1, medium attack button level
- btn_heavy, input, 1, heavy attack button level
- game_state, input, 2, 00 fight, 01 P1 wins, 10 P2 wins
- attack_state, output, 2, strike pulse: 00 none, 01 light, 10 medium, 11 heavy
- attack_type, output, 2, attack currently in progress (00 when idle)
- phase, output, 2, 00 IDLE, 01 STARTUP, 10 ACTIVE, 11 RECOVERY
- busy, output, 1, high whenever phase != IDLE

Behaviour:
- Reset (reset sampled high at a clk edge): phase=IDLE, attack_type=00, attack_state=00, busy=0, countdown=0, button history registers=0. Reset mid-attack aborts immediately; no strike pulse follows.
- Press detection: press_x = btn_x & ~btn_x_q, where btn_x_q is the previous-clk sample. Holding a button never retriggers.
- IDLE:
  - Any press while game_state==00 → STARTUP on the next clk.
  - Load attack_type; load countdown with that type's STARTUP value.
  - Simultaneous presses: heavy > medium > light.
- STARTUP, ACTIVE, RECOVERY:
  - Countdown decrements only on clk edges where frame_tick=1.
  - On a tick with countdown==1, advance: STARTUP→ACTIVE (load ACTIVE value), ACTIVE→RECOVERY (load RECOVERY value), RECOVERY→IDLE (attack_type←00).
- Strike pulse:
  - attack_state=attack_type for exactly the first clk cycle in which phase==ACTIVE; 00 otherwise.
  - Registered: set on the same edge as the STARTUP→ACTIVE transition, cleared on the next edge.
- Presses while busy are dropped (see optional feature).
- game_state != 00:
  - Any non-IDLE state → IDLE on the next clk; attack_type=00; no pulse.
  - If the pulse is already high that cycle, it is still cleared on the next edge (pulse width stays 1).
  - Presses are ignored while game_state != 00.
- No frame_tick: the machine holds its state indefinitely.
- Latency: press edge to strike pulse = STARTUP ticks, with the pulse 1 clk after the completing tick. Total busy time = STARTUP + ACTIVE + RECOVERY ticks.
- Countdown never underflows: loaded values are ≥1, and it only transitions at value 1.

Optional Feature:
- Macro: ATTACK_BUFFER_EN.
- Defined:
  - A 1-entry input buffer latches the highest-priority press seen during RECOVERY; a later press overwrites it only if it has higher priority.
  - On RECOVERY→IDLE the machine goes directly to STARTUP of the buffered type, consuming the buffer.
  - Buffer is cleared by reset, by game_state != 00, and by presses during STARTUP/ACTIVE (those are ignored, not buffered).
- Not defined: presses during any non-IDLE phase are dropped; no buffer register exists.

Test Plan:
- Light, defaults, tick every 4 clks: btn_light rises → phase 01 next clk; strike pulse attack_state=01 for 1 clk after the 2nd tick; phase 10 for 2 ticks, 11 for 4 ticks, then 00; busy is high throughout.
- btn_heavy and btn_light rise in the same clk → attack_type=11; single pulse 11 after 8 ticks; no light pulse at any point.
- btn_medium held high for 100 ticks → exactly one medium attack and one 10 pulse; phase returns to 00 and stays there.
- During STARTUP, game_state set to 01 → phase 00 next clk, attack_type 00, no pulse; new presses ignored until game_state returns to 00.
- reset asserted on the clk of the heavy STARTUP→ACTIVE tick → all outputs 0 next clk; no 11 pulse observed.
- ATTACK_BUFFER_EN: btn_light during RECOVERY of a medium → new light STARTUP begins on the clk of RECOVERY exit, light pulse follows 2 ticks later. Without the macro, the same stimulus returns to IDLE and no light pulse occurs.
